// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal synchronization barrier initiator.
package fractal_sync_pkg;

    // Initiator FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } tx_state_e;

    // Completion status returned to the local core
    typedef logic [1:0] done_status_t;

    localparam done_status_t ST_OK      = 2'd0;
    localparam done_status_t ST_SIG_ERR = 2'd1;
    localparam done_status_t ST_TIMEOUT = 2'd2;

endpackage : fractal_sync_pkg

// File: rtl/fractal_sync_tx_timer.sv
// Wait-limit down-counter. A zero load value disarms the timer so the
// barrier can wait indefinitely; expire_o marks the last waiting cycle.
module fractal_sync_tx_timer
    import fractal_sync_pkg::*;
#(
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     load_i,
    input  logic [TIMEOUT_WIDTH-1:0] load_val_i,
    input  logic                     en_i,
    output logic                     expire_o
);

    logic [TIMEOUT_WIDTH-1:0] count_q, count_d;
    logic                     armed_q, armed_d;

    // Next count: load on handshake, otherwise count down while waiting
    always_comb begin
        count_d = count_q;
        armed_d = armed_q;
        if (load_i) begin
            count_d = load_val_i;
            armed_d = |load_val_i;
        end else if (en_i && armed_q && (count_q != {TIMEOUT_WIDTH{1'b0}})) begin
            count_d = count_q - {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter registers with synchronous clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= {TIMEOUT_WIDTH{1'b0}};
            armed_q <= 1'b0;
        end else begin
            count_q <= count_d;
            armed_q <= armed_d;
        end
    end

    assign expire_o = armed_q && (count_q == {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1});

endmodule : fractal_sync_tx_timer

// File: rtl/fractal_sync_tx.sv
// Initiator end of the fractal barrier: sends one request into the remote
// RF tree, waits for its wake-up (or a timeout) and reports completion.
module fractal_sync_tx
    import fractal_sync_pkg::*;
#(
    parameter int LEVEL_WIDTH   = 1,
    parameter int ID_WIDTH      = 1,
    parameter int TIMEOUT_WIDTH = 16,
    parameter int STRAY_WIDTH   = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [LEVEL_WIDTH-1:0]   req_level_i,
    input  logic [ID_WIDTH-1:0]      req_id_i,
    output logic                     sync_valid_o,
    input  logic                     sync_ready_i,
    output logic [LEVEL_WIDTH-1:0]   sync_level_o,
    output logic [ID_WIDTH-1:0]      sync_id_o,
    input  logic                     wake_valid_i,
    input  logic [LEVEL_WIDTH-1:0]   wake_level_i,
    input  logic [ID_WIDTH-1:0]      wake_id_i,
    input  logic                     wake_err_i,
    output logic                     done_valid_o,
    input  logic                     done_ready_i,
    output logic [1:0]               done_status_o,
    output logic                     busy_o,
    output logic [STRAY_WIDTH-1:0]   stray_cnt_o
);

    tx_state_e                state_q, state_d;
    logic [LEVEL_WIDTH-1:0]   level_q, level_d;
    logic [ID_WIDTH-1:0]      id_q, id_d;
    done_status_t             status_q, status_d;
    logic [STRAY_WIDTH-1:0]   stray_q, stray_d;

    logic wake_match_s;
    logic stray_inc_s;
    logic timer_load_s;
    logic timer_en_s;
    logic timer_expire_s;

    assign wake_match_s = (wake_level_i == level_q) && (wake_id_i == id_q);
    assign timer_en_s   = (state_q == S_WAIT);

    fractal_sync_tx_timer #(
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (timer_load_s),
        .load_val_i (timeout_i),
        .en_i       (timer_en_s),
        .expire_o   (timer_expire_s)
    );

    // Next-state, field capture and completion status
    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        id_d         = id_q;
        status_d     = status_q;
        timer_load_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    level_d = req_level_i;
                    id_d    = req_id_i;
                    state_d = S_SEND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                if (sync_ready_i) begin
                    timer_load_s = 1'b1;
                    state_d      = S_WAIT;
                end else begin
                    state_d = S_SEND;
                end
            end
            S_WAIT: begin
                // A matching wake beats a timeout landing in the same cycle
                if (wake_valid_i && wake_match_s) begin
                    status_d = wake_err_i ? ST_SIG_ERR : ST_OK;
                    state_d  = S_DONE;
                end else if (timer_expire_s) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                if (done_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Any wake that does not complete the in-flight barrier is a stray
    always_comb begin
        stray_inc_s = wake_valid_i && !((state_q == S_WAIT) && wake_match_s);
        if (stray_inc_s && (stray_q != {STRAY_WIDTH{1'b1}})) begin
            stray_d = stray_q + {{(STRAY_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            stray_d = stray_q;
        end
    end

    // State and field registers; reset abandons any barrier in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            level_q  <= {LEVEL_WIDTH{1'b0}};
            id_q     <= {ID_WIDTH{1'b0}};
            status_q <= ST_OK;
            stray_q  <= {STRAY_WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            id_q     <= id_d;
            status_q <= status_d;
            stray_q  <= stray_d;
        end
    end

    assign req_ready_o   = (state_q == S_IDLE);
    assign sync_valid_o  = (state_q == S_SEND);
    assign sync_level_o  = level_q;
    assign sync_id_o     = id_q;
    assign done_valid_o  = (state_q == S_DONE);
    assign done_status_o = status_q;
    assign busy_o        = (state_q != S_IDLE);
    assign stray_cnt_o   = stray_q;

endmodule : fractal_sync_tx

// File: tb/tb_fractal_sync_tx.sv
// Directed bench for fractal_sync_tx with LEVEL_WIDTH=2, ID_WIDTH=3.
module tb_fractal_sync_tx;

    localparam int LW = 2;
    localparam int IW = 3;
    localparam int TW = 16;
    localparam int SW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [TW-1:0] timeout_i = '0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [LW-1:0] req_level_i = '0;
    logic [IW-1:0] req_id_i = '0;
    logic          sync_valid_o;
    logic          sync_ready_i = 1'b0;
    logic [LW-1:0] sync_level_o;
    logic [IW-1:0] sync_id_o;
    logic          wake_valid_i = 1'b0;
    logic [LW-1:0] wake_level_i = '0;
    logic [IW-1:0] wake_id_i = '0;
    logic          wake_err_i = 1'b0;
    logic          done_valid_o;
    logic          done_ready_i = 1'b0;
    logic [1:0]    done_status_o;
    logic          busy_o;
    logic [SW-1:0] stray_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    fractal_sync_tx #(
        .LEVEL_WIDTH   (LW),
        .ID_WIDTH      (IW),
        .TIMEOUT_WIDTH (TW),
        .STRAY_WIDTH   (SW)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .timeout_i     (timeout_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_level_i   (req_level_i),
        .req_id_i      (req_id_i),
        .sync_valid_o  (sync_valid_o),
        .sync_ready_i  (sync_ready_i),
        .sync_level_o  (sync_level_o),
        .sync_id_o     (sync_id_o),
        .wake_valid_i  (wake_valid_i),
        .wake_level_i  (wake_level_i),
        .wake_id_i     (wake_id_i),
        .wake_err_i    (wake_err_i),
        .done_valid_o  (done_valid_o),
        .done_ready_i  (done_ready_i),
        .done_status_o (done_status_o),
        .busy_o        (busy_o),
        .stray_cnt_o   (stray_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ".req_ready"},  32'(req_ready_o),   32'd1);
        check_eq({tag, ".sync_valid"}, 32'(sync_valid_o),  32'd0);
        check_eq({tag, ".sync_level"}, 32'(sync_level_o),  32'd0);
        check_eq({tag, ".sync_id"},    32'(sync_id_o),     32'd0);
        check_eq({tag, ".done_valid"}, 32'(done_valid_o),  32'd0);
        check_eq({tag, ".status"},     32'(done_status_o), 32'd0);
        check_eq({tag, ".busy"},       32'(busy_o),        32'd0);
        check_eq({tag, ".stray"},      32'(stray_cnt_o),   32'd0);
    endtask

    // Request accepted then immediate handshake; returns just after the handshake edge
    task automatic start_barrier(input logic [LW-1:0] lv, input logic [IW-1:0] id);
        req_valid_i  = 1'b1;
        req_level_i  = lv;
        req_id_i     = id;
        sync_ready_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        step();
        sync_ready_i = 1'b0;
    endtask

    task automatic send_wake(input logic [LW-1:0] lv, input logic [IW-1:0] id, input logic err);
        wake_valid_i = 1'b1;
        wake_level_i = lv;
        wake_id_i    = id;
        wake_err_i   = err;
        step();
        wake_valid_i = 1'b0;
        wake_err_i   = 1'b0;
    endtask

    task automatic finish_done();
        done_ready_i = 1'b1;
        step();
        done_ready_i = 1'b0;
    endtask

    initial begin
        // Reset
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check_reset_vals("reset");

        // 1: basic barrier, wake 3 cycles after handshake
        req_valid_i  = 1'b1;
        req_level_i  = 2'd1;
        req_id_i     = 3'd5;
        sync_ready_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        check_eq("t1.sync_valid", 32'(sync_valid_o), 32'd1);
        check_eq("t1.sync_level", 32'(sync_level_o), 32'd1);
        check_eq("t1.sync_id",    32'(sync_id_o),    32'd5);
        check_eq("t1.req_ready",  32'(req_ready_o),  32'd0);
        step();
        sync_ready_i = 1'b0;
        check_eq("t1.sync_dropped", 32'(sync_valid_o), 32'd0);
        step();
        step();
        check_eq("t1.no_done_early", 32'(done_valid_o), 32'd0);
        check_eq("t1.busy",          32'(busy_o),       32'd1);
        send_wake(2'd1, 3'd5, 1'b0);
        check_eq("t1.done_valid", 32'(done_valid_o),  32'd1);
        check_eq("t1.status",     32'(done_status_o), 32'd0);
        check_eq("t1.stray",      32'(stray_cnt_o),   32'd0);
        finish_done();
        check_eq("t1.idle", 32'(req_ready_o), 32'd1);

        // 2: backpressure on sync, timer only starts at handshake
        timeout_i   = 16'd3;
        req_valid_i = 1'b1;
        req_level_i = 2'd1;
        req_id_i    = 3'd5;
        step();
        req_valid_i = 1'b0;
        req_level_i = 2'd0;
        req_id_i    = 3'd0;
        for (int i = 0; i < 5; i++) begin
            check_eq("t2.sync_valid", 32'(sync_valid_o), 32'd1);
            check_eq("t2.sync_level", 32'(sync_level_o), 32'd1);
            check_eq("t2.sync_id",    32'(sync_id_o),    32'd5);
            check_eq("t2.busy",       32'(busy_o),       32'd1);
            step();
        end
        check_eq("t2.still_send", 32'(sync_valid_o), 32'd1);
        sync_ready_i = 1'b1;
        step();
        sync_ready_i = 1'b0;
        step();
        step();
        check_eq("t2.no_timeout_yet", 32'(done_valid_o), 32'd0);
        step();
        check_eq("t2.timeout_done",   32'(done_valid_o),  32'd1);
        check_eq("t2.timeout_status", 32'(done_status_o), 32'd2);
        finish_done();
        timeout_i = 16'd0;

        // 3: signature error, completion held under backpressure
        start_barrier(2'd1, 3'd5);
        send_wake(2'd1, 3'd5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_eq("t3.done_held",   32'(done_valid_o),  32'd1);
            check_eq("t3.status_held", 32'(done_status_o), 32'd1);
            step();
        end
        done_ready_i = 1'b1;
        step();
        done_ready_i = 1'b0;
        check_eq("t3.idle_busy", 32'(busy_o),       32'd0);
        check_eq("t3.idle_done", 32'(done_valid_o), 32'd0);

        // 4: mismatched wake during WAIT, then saturation in IDLE
        start_barrier(2'd1, 3'd5);
        send_wake(2'd0, 3'd5, 1'b0);
        check_eq("t4.stray_one",  32'(stray_cnt_o),  32'd1);
        check_eq("t4.still_wait", 32'(done_valid_o), 32'd0);
        send_wake(2'd1, 3'd5, 1'b0);
        check_eq("t4.done",   32'(done_valid_o),  32'd1);
        check_eq("t4.status", 32'(done_status_o), 32'd0);
        check_eq("t4.stray_after_match", 32'(stray_cnt_o), 32'd1);
        finish_done();
        wake_valid_i = 1'b1;
        wake_level_i = 2'd1;
        wake_id_i    = 3'd5;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 252) check_eq("t4.stray_254", 32'(stray_cnt_o), 32'd254);
        end
        wake_valid_i = 1'b0;
        check_eq("t4.stray_sat", 32'(stray_cnt_o), 32'd255);
        check_eq("t4.idle",      32'(busy_o),      32'd0);

        // 5a: timeout of 10 cycles
        timeout_i = 16'd10;
        start_barrier(2'd2, 3'd3);
        for (int i = 0; i < 9; i++) step();
        check_eq("t5.no_done_at_10", 32'(done_valid_o), 32'd0);
        step();
        check_eq("t5.timeout_done",   32'(done_valid_o),  32'd1);
        check_eq("t5.timeout_status", 32'(done_status_o), 32'd2);
        finish_done();

        // 5b: matching wake in the expiry cycle wins
        start_barrier(2'd2, 3'd3);
        for (int i = 0; i < 9; i++) step();
        send_wake(2'd2, 3'd3, 1'b0);
        check_eq("t5.race_done",   32'(done_valid_o),  32'd1);
        check_eq("t5.race_status", 32'(done_status_o), 32'd0);
        finish_done();

        // 5c: timeout disabled
        timeout_i = 16'd0;
        start_barrier(2'd3, 3'd7);
        for (int i = 0; i < 1000; i++) step();
        check_eq("t5.inf_busy", 32'(busy_o),       32'd1);
        check_eq("t5.inf_done", 32'(done_valid_o), 32'd0);
        send_wake(2'd3, 3'd7, 1'b0);
        check_eq("t5.inf_exit", 32'(done_valid_o), 32'd1);
        finish_done();

        // 6: reset mid-WAIT abandons the barrier silently
        start_barrier(2'd1, 3'd5);
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check_reset_vals("t6.rst");
        step();
        check_eq("t6.no_done", 32'(done_valid_o), 32'd0);
        send_wake(2'd1, 3'd5, 1'b0);
        check_eq("t6.late_stray", 32'(stray_cnt_o),  32'd1);
        check_eq("t6.late_idle",  32'(busy_o),       32'd0);
        check_eq("t6.late_done",  32'(done_valid_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fractal_sync_tx

// File: doc/fractal_sync_tx.md
Name: fractal_sync_tx

Overview:
Initiator end of the fractal synchronization barrier protocol. It accepts one local barrier request (level, id) and issues it toward the remote register file tree with a valid/ready handshake. It then waits for the matching wake-up, which can carry a signature error, or for a programmable timeout, and returns a completion status to the local core. One instance sits per node port, on the requester side of each remote RF port.

Parameters:
LEVEL_WIDTH, 1, width of barrier level field
ID_WIDTH, 1, width of barrier id field
TIMEOUT_WIDTH, 16, width of timeout counter
STRAY_WIDTH, 8, width of saturating stray-wake counter

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
timeout_i  in  TIMEOUT_WIDTH  wait limit in cycles; 0 = disabled
req_valid_i  in  1  local barrier request valid
req_ready_o  out  1  request accepted when high with req_valid_i
req_level_i  in  LEVEL_WIDTH  requested level
req_id_i  in  ID_WIDTH  requested id
sync_valid_o  out  1  outgoing sync request valid
sync_ready_i  in  1  network accepts sync request
sync_level_o  out  LEVEL_WIDTH  outgoing level
sync_id_o  out  ID_WIDTH  outgoing id
wake_valid_i  in  1  wake-up pulse from network, single cycle, no backpressure
wake_level_i  in  LEVEL_WIDTH  wake level
wake_id_i  in  ID_WIDTH  wake id
wake_err_i  in  1  wake carries signature error
done_valid_o  out  1  completion valid
done_ready_i  in  1  local side consumes completion
done_status_o  out  2  0 OK, 1 SIG_ERR, 2 TIMEOUT
busy_o  out  1  barrier in flight (state != IDLE)
stray_cnt_o  out  STRAY_WIDTH  count of unmatched wakes, saturating

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values, from the cycle after rst_i is sampled high: state IDLE, req_ready_o=1, sync_valid_o=0, sync_level_o=0, sync_id_o=0, done_valid_o=0, done_status_o=0, busy_o=0, stray_cnt_o=0, timer=0.
- FSM states: IDLE, SEND, WAIT, DONE. All outputs are decoded from registered state and registered fields.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, capture level and id, go to SEND.
- SEND:
  - sync_valid_o=1; sync_level_o and sync_id_o held stable until sync_ready_i.
  - On handshake, load timer with timeout_i (sampled only here) and go to WAIT.
  - sync_valid_o never drops without a handshake, except on reset.
- WAIT, on wake_valid_i:
  - If wake_level_i and wake_id_i equal the captured fields: status = wake_err_i ? SIG_ERR : OK, go to DONE.
  - Otherwise stray_cnt_o increments.
- WAIT, timer:
  - If the latched timeout is nonzero, the timer decrements each cycle.
  - In the cycle the timer equals 1 with no match: status = TIMEOUT, go to DONE.
  - Matching wake in the expiry cycle: the match wins (OK or SIG_ERR).
  - Latched timeout 0: wait indefinitely.
- DONE:
  - done_valid_o=1 with done_status_o stable until done_ready_i, then go to IDLE.
- Wakes outside WAIT: any wake_valid_i in IDLE, SEND or DONE increments stray_cnt_o.
- stray_cnt_o saturates at all-ones and never wraps. It is cleared only by reset.
- Latency:
  - Request accepted in cycle t -> sync_valid_o high at t+1.
  - Matching wake in cycle w -> done_valid_o high at w+1.
  - Sync handshake in cycle h with timeout_i=N -> TIMEOUT done_valid_o at h+N+1.
- Throughput: one barrier in flight. req_ready_o is low outside IDLE, so a new request needs at least 4 cycles with zero stalls.
- Reset mid-operation: the in-flight barrier is abandoned silently and no done is issued. Captured fields and the timer are cleared.
- Width rules: level/id comparisons are exact-width equality; no sign extension.

Decomposition:
- fractal_sync_pkg holds:
  - the tx state enum (IDLE, SEND, WAIT, DONE)
  - the 2-bit done status typedef with constants ST_OK, ST_SIG_ERR, ST_TIMEOUT
- Sub-module fractal_sync_tx_timer:
  - ports: load, load value, enable
  - output: expire flag, asserted when the count equals 1 and the latched value is nonzero
  - implemented as a down-counter of TIMEOUT_WIDTH bits

Test Plan:
1. LEVEL_WIDTH=2, ID_WIDTH=3: req level=1 id=5, sync_ready_i=1, matching wake (err=0) 3 cycles after handshake -> done_valid_o one cycle after wake, status 0, stray_cnt_o=0.
2. sync_ready_i low for 5 cycles after SEND entry -> sync_valid_o=1 and sync_level_o=1/sync_id_o=5 stable all 5 cycles; busy_o=1; no timeout counting before the handshake.
3. Matching wake with wake_err_i=1 -> done_status_o=1. Hold done_ready_i low 4 cycles -> done_valid_o and status held; IDLE the cycle after done_ready_i.
4. During WAIT, wake level=0 id=5, then the matching wake -> stray_cnt_o=1, status 0. Then 300 wakes in IDLE -> stray_cnt_o=255.
5. timeout_i=10, no wake -> status 2 with done_valid_o exactly 11 cycles after handshake. Repeat with a matching wake in the expiry cycle -> status 0. timeout_i=0 with no wake for 1000 cycles -> still WAIT, busy_o=1.
6. rst_i pulsed one cycle mid-WAIT -> next cycle all outputs at reset values, no done. A later late-matching wake in IDLE -> stray_cnt_o=1.
